// File: rtl/wb_scoreboard.sv
// Issue-hazard scoreboard plus round-robin ALU/LSU writeback arbiter for the 32x32 register file.
// Optional macro WB_BYPASS_EN: the register being written back this cycle no longer counts as busy for issue.
module wb_scoreboard #(
    parameter int MAX_OUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             issue_valid,
    input  logic             issue_wr,
    input  logic [4:0]       issue_rd,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    output logic             issue_stall,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [31:0]      alu_data,
    output logic             alu_ready,
    input  logic             lsu_valid,
    input  logic [4:0]       lsu_rd,
    input  logic [31:0]      lsu_data,
    output logic             lsu_ready,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [31:0]      busy,
    output logic [CNT_W-1:0] outstanding,
    output logic             wb_err
);

    logic             rr_lsu;
    logic [31:0]      busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wb_fire;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic [31:0]      clr_vec;
    logic [31:0]      set_vec;
    logic [31:0]      busy_eff;
    logic             alloc;
    logic             wb_hit;
    logic             wb_miss;
    logic             collide;
    logic             full;
    logic [31:0]      busy_next;
    logic [CNT_W-1:0] cnt_next;

    // rr_lsu=1 means the LSU wins the next two-way contention
    assign alu_ready = alu_valid & (~lsu_valid | ~rr_lsu);
    assign lsu_ready = lsu_valid & (~alu_valid | rr_lsu);
    assign wb_fire   = alu_ready | lsu_ready;
    assign wb_rd     = alu_ready ? alu_rd : lsu_rd;
    assign wb_data   = alu_ready ? alu_data : lsu_data;

    always_comb begin
        clr_vec = 32'd0;
        if (wb_fire && wb_rd != 5'd0)
            clr_vec = 32'd1 << wb_rd;
    end

`ifdef WB_BYPASS_EN
    assign busy_eff = busy_q & ~clr_vec;
`else
    assign busy_eff = busy_q;
`endif

    assign full = (cnt_q == CNT_W'(MAX_OUT));

    always_comb begin
        issue_stall = 1'b0;
        if (issue_valid) begin
            if (issue_rs1 != 5'd0 && busy_eff[issue_rs1])
                issue_stall = 1'b1;
            if (issue_rs2 != 5'd0 && busy_eff[issue_rs2])
                issue_stall = 1'b1;
            if (issue_wr && issue_rd != 5'd0 && (busy_eff[issue_rd] || full))
                issue_stall = 1'b1;
        end
    end

    assign alloc = issue_valid & ~issue_stall & issue_wr & (issue_rd != 5'd0);

    always_comb begin
        set_vec = 32'd0;
        if (alloc)
            set_vec = 32'd1 << issue_rd;
    end

    assign wb_hit  = wb_fire && wb_rd != 5'd0 && busy_q[wb_rd];
    assign wb_miss = wb_fire && wb_rd != 5'd0 && !busy_q[wb_rd];
    // Same-edge set and clear of one register: set wins but it is still flagged
    assign collide = alloc && wb_fire && (wb_rd == issue_rd);

    assign busy_next = ((busy_q & ~clr_vec) | set_vec) & ~32'd1;

    always_comb begin
        cnt_next = cnt_q;
        if (alloc && !wb_hit)
            cnt_next = cnt_q + CNT_W'(1);
        else if (!alloc && wb_hit)
            cnt_next = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rr_lsu   <= 1'b0;
            busy_q   <= 32'd0;
            cnt_q    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
            wb_err   <= 1'b0;
        end else begin
            busy_q <= busy_next;
            cnt_q  <= cnt_next;
            rf_we  <= wb_fire && (wb_rd != 5'd0);
            if (wb_fire) begin
                rf_waddr <= wb_rd;
                rf_wdata <= wb_data;
            end
            if (alu_valid && lsu_valid)
                rr_lsu <= alu_ready;
            if (wb_miss || collide)
                wb_err <= 1'b1;
        end
    end

    assign busy        = busy_q;
    assign outstanding = cnt_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed scenarios plus randomized traffic against a reference model.
// Honours WB_BYPASS_EN the same way the design does.
module tb_wb_scoreboard;

    localparam int MAX_OUT = 8;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             clrn;
    logic             issue_valid, issue_wr;
    logic [4:0]       issue_rd, issue_rs1, issue_rs2;
    logic             issue_stall;
    logic             alu_valid, lsu_valid;
    logic [4:0]       alu_rd, lsu_rd;
    logic [31:0]      alu_data, lsu_data;
    logic             alu_ready, lsu_ready;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [31:0]      rf_wdata;
    logic [31:0]      busy;
    logic [CNT_W-1:0] outstanding;
    logic             wb_err;

    int checks = 0;
    int errors = 0;

    wb_scoreboard #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .clrn(clrn),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy(busy), .outstanding(outstanding), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // reference model: a pending flag per register, a count, and who won the last contention
    bit         m_pend [32];
    int         m_cnt;
    bit         m_err;
    bit         m_last_alu;
    bit         m_we;
    bit [4:0]   m_waddr;
    bit [31:0]  m_wdata;
    bit         e_stall, e_ar, e_lr;

    function automatic bit [31:0] m_busy();
        bit [31:0] v = 0;
        for (int r = 1; r < 32; r++) v[r] = m_pend[r];
        return v;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
        m_cnt = 0; m_err = 0; m_last_alu = 0;
        m_we = 0; m_waddr = 0; m_wdata = 0;
    endfunction

    function automatic bit blocked(input bit [4:0] r, input bit fire, input bit [4:0] wr);
        if (r == 0 || !m_pend[r]) return 0;
        if (BYPASS && fire && wr == r) return 0;
        return 1;
    endfunction

    function automatic void model_eval();
        bit fire;
        bit [4:0] wr;
        if (alu_valid && lsu_valid) begin
            e_ar = !m_last_alu;
            e_lr = m_last_alu;
        end else begin
            e_ar = alu_valid;
            e_lr = lsu_valid;
        end
        fire = e_ar || e_lr;
        wr = e_ar ? alu_rd : lsu_rd;
        e_stall = issue_valid && (blocked(issue_rs1, fire, wr) || blocked(issue_rs2, fire, wr) ||
                  (issue_wr && issue_rd != 0 && (blocked(issue_rd, fire, wr) || m_cnt == MAX_OUT)));
    endfunction

    function automatic void model_commit();
        bit [4:0] wr;
        bit [31:0] wd;
        bit fire;
        model_eval();
        fire = e_ar || e_lr;
        wr = e_ar ? alu_rd : lsu_rd;
        wd = e_ar ? alu_data : lsu_data;
        m_we = fire && wr != 0;
        if (fire) begin
            m_waddr = wr;
            m_wdata = wd;
            if (wr != 0) begin
                if (m_pend[wr]) begin m_pend[wr] = 0; m_cnt--; end
                else m_err = 1;
            end
        end
        if (issue_valid && !e_stall && issue_wr && issue_rd != 0) begin
            if (fire && wr == issue_rd) m_err = 1;
            m_pend[issue_rd] = 1;
            m_cnt++;
        end
        if (alu_valid && lsu_valid) m_last_alu = e_ar;
    endfunction

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_wr = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int r = 1; r < 32; r++) begin
            if (m_pend[r]) begin
                alu_valid = 1; alu_rd = 5'(r); alu_data = $urandom;
                tick();
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        clrn = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
        checks++; if (outstanding !== '0) begin errors++; $display("FAIL reset_outstanding got %0d want 0", outstanding); end
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            errors++; $display("FAIL reset_rf got we=%b a=%0d d=%h want 0", rf_we, rf_waddr, rf_wdata); end
        checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", wb_err); end
        clrn = 1;
        #1;
    endtask

    task automatic test_alloc();
        issue_valid = 1; issue_wr = 1; issue_rd = 5;
        #1;
        checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL alloc_first_stall got %b want 0", issue_stall); end
        tick();
        checks++; if (busy !== 32'h0000_0020) begin errors++; $display("FAIL alloc_busy got %h want 00000020", busy); end
        checks++; if (outstanding !== 4'd1) begin errors++; $display("FAIL alloc_cnt got %0d want 1", outstanding); end
        issue_wr = 0; issue_rd = 0; issue_rs1 = 5;
        #1;
        checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall got %b want 1", issue_stall); end
        tick();
    endtask

    task automatic test_alu_wb();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %b want 1", alu_ready); end
        checks++; if (issue_stall !== !BYPASS) begin errors++; $display("FAIL wb_cycle_stall got %b want %b", issue_stall, !BYPASS); end
        tick();
        alu_valid = 0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL alu_wb_rf got we=%b a=%0d d=%h want 1/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
        checks++; if (busy !== 32'd0 || outstanding !== 4'd0) begin
            errors++; $display("FAIL alu_wb_clear got busy=%h cnt=%0d want 0/0", busy, outstanding); end
        #1;
        checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL raw_release got %b want 0", issue_stall); end
        tick();
        idle_inputs();
    endtask

    task automatic test_contention();
        issue_valid = 1; issue_wr = 1; issue_rd = 3; tick();
        issue_rd = 7; tick();
        idle_inputs();
        alu_valid = 1; alu_rd = 3; alu_data = 32'h1111_0003;
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h2222_0007;
        #1;
        checks++; if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
            errors++; $display("FAIL rr_first got alu=%b lsu=%b want 1/0", alu_ready, lsu_ready); end
        tick();
        alu_valid = 0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin
            errors++; $display("FAIL rr_wb1 got we=%b a=%0d want 1/3", rf_we, rf_waddr); end
        #1;
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL rr_second got %b want 1", lsu_ready); end
        tick();
        lsu_valid = 0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h2222_0007) begin
            errors++; $display("FAIL rr_wb2 got we=%b a=%0d d=%h want 1/7/22220007", rf_we, rf_waddr, rf_wdata); end
        tick();
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd7 || rf_wdata !== 32'h2222_0007) begin
            errors++; $display("FAIL rf_hold got we=%b a=%0d d=%h want 0/7/22220007", rf_we, rf_waddr, rf_wdata); end
        // both valid again: ALU won last contention, so LSU should win now
        alu_valid = 1; alu_rd = 0; lsu_valid = 1; lsu_rd = 0;
        #1;
        checks++; if (alu_ready !== 1'b0 || lsu_ready !== 1'b1) begin
            errors++; $display("FAIL rr_alternate got alu=%b lsu=%b want 0/1", alu_ready, lsu_ready); end
        tick();
        lsu_valid = 0;
        checks++; if (rf_we !== 1'b0 || wb_err !== 1'b0) begin
            errors++; $display("FAIL wb_x0 got we=%b err=%b want 0/0", rf_we, wb_err); end
        tick();
        idle_inputs();
    endtask

    task automatic test_full();
        for (int i = 1; i <= MAX_OUT; i++) begin
            issue_valid = 1; issue_wr = 1; issue_rd = 5'(i);
            tick();
        end
        checks++; if (outstanding !== 4'(MAX_OUT) || busy !== 32'h0000_01FE) begin
            errors++; $display("FAIL full_cnt got cnt=%0d busy=%h want 8/000001fe", outstanding, busy); end
        issue_rd = 9;
        #1;
        checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b want 1", issue_stall); end
        issue_wr = 0; issue_rd = 0; issue_rs1 = 10; issue_rs2 = 11;
        #1;
        checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL full_nowrite got %b want 0", issue_stall); end
        issue_wr = 1; issue_rd = 9; issue_rs1 = 0; issue_rs2 = 0;
        lsu_valid = 1; lsu_rd = 1; lsu_data = 32'h0000_00A1;
        #1;
        checks++; if (issue_stall !== 1'b1) begin errors++; $display("FAIL full_wb_cycle got %b want 1", issue_stall); end
        tick();
        lsu_valid = 0;
        #1;
        checks++; if (issue_stall !== 1'b0) begin errors++; $display("FAIL full_release got %b want 0", issue_stall); end
        tick();
        checks++; if (busy !== 32'h0000_03FC || outstanding !== 4'd8) begin
            errors++; $display("FAIL full_realloc got busy=%h cnt=%0d want 000003fc/8", busy, outstanding); end
        drain();
    endtask

    task automatic test_err_reset();
        lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h0BAD_0009;
        #1;
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL err_ready got %b want 1", lsu_ready); end
        tick();
        lsu_valid = 0;
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || wb_err !== 1'b1 || outstanding !== 4'd0) begin
            errors++; $display("FAIL err_write got we=%b a=%0d err=%b cnt=%0d want 1/9/1/0", rf_we, rf_waddr, wb_err, outstanding); end
        issue_valid = 1; issue_wr = 1; issue_rd = 12; tick();
        issue_rd = 13; alu_valid = 1; alu_rd = 12; alu_data = 32'hCAFE_000C; tick();
        checks++; if (wb_err !== 1'b1 || rf_we !== 1'b1) begin
            errors++; $display("FAIL err_sticky got err=%b we=%b want 1/1", wb_err, rf_we); end
        #2;
        clrn = 0;
        #1;
        checks++; if (busy !== 0 || outstanding !== 0 || rf_we !== 0 || rf_waddr !== 0 || rf_wdata !== 0 || wb_err !== 0) begin
            errors++; $display("FAIL async_reset got busy=%h cnt=%0d we=%b a=%0d d=%h err=%b want all 0",
                               busy, outstanding, rf_we, rf_waddr, rf_wdata, wb_err); end
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        clrn = 1;
        #1;
    endtask

    task automatic test_bypass();
        issue_valid = 1; issue_wr = 1; issue_rd = 4; tick();
        issue_wr = 0; issue_rd = 0; issue_rs2 = 4;
        alu_valid = 1; alu_rd = 4; alu_data = 32'h4444_4444;
        #1;
        checks++; if (issue_stall !== !BYPASS) begin errors++; $display("FAIL bypass_stall got %b want %b", issue_stall, !BYPASS); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        bit acc_a, acc_l;
        bit [4:0] pick [$];
        acc_a = 0; acc_l = 0;
        idle_inputs();
        for (int cyc = 0; cyc < 600; cyc++) begin
            issue_valid = ($urandom_range(0, 3) != 0);
            issue_wr    = $urandom_range(0, 1);
            issue_rd    = 5'($urandom_range(0, 12));
            issue_rs1   = 5'($urandom_range(0, 12));
            issue_rs2   = 5'($urandom_range(0, 12));
            if (alu_valid && acc_a) alu_valid = 0;
            if (lsu_valid && acc_l) lsu_valid = 0;
            if (!alu_valid && $urandom_range(0, 1)) begin
                pick.delete();
                for (int r = 1; r < 32; r++)
                    if (m_pend[r] && !(lsu_valid && lsu_rd == r)) pick.push_back(5'(r));
                if (pick.size() > 0) begin
                    alu_valid = 1; alu_rd = pick[$urandom_range(0, pick.size() - 1)]; alu_data = $urandom;
                end
            end
            if (!lsu_valid && $urandom_range(0, 1)) begin
                pick.delete();
                for (int r = 1; r < 32; r++)
                    if (m_pend[r] && !(alu_valid && alu_rd == r)) pick.push_back(5'(r));
                if (pick.size() > 0) begin
                    lsu_valid = 1; lsu_rd = pick[$urandom_range(0, pick.size() - 1)]; lsu_data = $urandom;
                end
            end
            #1;
            model_eval();
            checks++; if (issue_stall !== e_stall || alu_ready !== e_ar || lsu_ready !== e_lr) begin
                errors++; $display("FAIL rand_comb cyc=%0d got stall=%b ar=%b lr=%b want %b/%b/%b",
                                   cyc, issue_stall, alu_ready, lsu_ready, e_stall, e_ar, e_lr); end
            acc_a = e_ar; acc_l = e_lr;
            tick();
            checks++; if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata || busy !== m_busy() ||
                          outstanding !== CNT_W'(m_cnt) || wb_err !== m_err) begin
                errors++; $display("FAIL rand_state cyc=%0d got we=%b a=%0d d=%h busy=%h cnt=%0d err=%b want %b/%0d/%h/%h/%0d/%b",
                                   cyc, rf_we, rf_waddr, rf_wdata, busy, outstanding, wb_err,
                                   m_we, m_waddr, m_wdata, m_busy(), m_cnt, m_err); end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_alu_wb();
        test_contention();
        test_full();
        test_err_reset();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
